// File: rtl/word_assembler.sv
// word_assembler
// Collects classified letters into a packed word (letter k at bits [5k+4:5k]),
// submits the word to a dictionary block, and commits either the corrected
// word or, on dictionary timeout, the raw buffered word.
//
// Ports
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous reset, active-HIGH despite the name
//   i_letter_valid  strobe: i_letter carries a letter code (1..26, 0 = padding)
//   i_letter        5-bit letter code
//   i_backspace     strobe: drop the last stored letter
//   i_end           strobe: end of word, submit to dictionary
//   o_ready         high while collecting; strobes are accepted only then
//   o_dict_start    one-cycle start pulse to the dictionary
//   o_dict_word     packed word to the dictionary, stable until commit
//   i_dict_finish   dictionary done (first high cycle in WAIT is used)
//   i_dict_word     corrected word, valid while i_dict_finish is high
//   o_word_valid    one-cycle commit pulse qualifying o_word/o_len/o_timeout
//   o_word          committed word, held until the next commit
//   o_len           letter count of the submitted word
//   o_overflow      sticky: a letter was dropped on a full buffer
//   o_timeout       1 = dictionary timed out, o_word is the raw word
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | accepting letters / backspace / end
// START   | one-cycle dictionary start pulse, timeout counter cleared
// WAIT    | waiting for dictionary finish or timeout
// DONE    | one-cycle commit pulse, buffer/len/overflow cleared
module word_assembler #(
  parameter int MAX_LEN     = 24,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_letter_valid,
  input  logic [4:0]                     i_letter,
  input  logic                           i_backspace,
  input  logic                           i_end,
  output logic                           o_ready,
  output logic                           o_dict_start,
  output logic [5*MAX_LEN-1:0]           o_dict_word,
  input  logic                           i_dict_finish,
  input  logic [5*MAX_LEN-1:0]           i_dict_word,
  output logic                           o_word_valid,
  output logic [5*MAX_LEN-1:0]           o_word,
  output logic [$clog2(MAX_LEN+1)-1:0]   o_len,
  output logic                           o_overflow,
  output logic                           o_timeout
);

  localparam int W     = 5 * MAX_LEN;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] START   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     buf_q, buf_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [W-1:0]     word_q, word_d;
  logic [LEN_W-1:0] olen_q, olen_d;
  logic             to_q, to_d;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    olen_d  = olen_q;
    to_d    = to_q;

    case (state_q)
      COLLECT: begin
        // ready_q is low on the first cycle after reset release, so strobes
        // seen then are discarded even though the state is already COLLECT.
        if (ready_q) begin
          if (i_backspace) begin
            // Backspace wins; a same-cycle letter is dropped.
            if (len_q != '0) begin
              for (int k = 0; k < MAX_LEN; k++) begin
                if (LEN_W'(k + 1) == len_q) buf_d[5*k +: 5] = 5'd0;
              end
              len_d = len_q - LEN_W'(1);
            end
          end else if (i_letter_valid && (i_letter != 5'd0)) begin
            if (len_q < LEN_W'(MAX_LEN)) begin
              for (int k = 0; k < MAX_LEN; k++) begin
                if (LEN_W'(k) == len_q) buf_d[5*k +: 5] = i_letter;
              end
              len_d = len_q + LEN_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          // End sees the length after any same-cycle edit.
          if (i_end && (len_d != '0)) state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_dict_finish) begin
          word_d  = i_dict_word;
          to_d    = 1'b0;
          olen_d  = len_q;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          word_d  = buf_q;
          to_d    = 1'b1;
          olen_d  = len_q;
          state_d = DONE;
        end
      end
      default: begin
        buf_d   = '0;
        len_d   = '0;
        ovf_d   = 1'b0;
        state_d = COLLECT;
      end
    endcase

    ready_d = (state_d == COLLECT);
  end

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_q <= COLLECT;
      buf_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      word_q  <= '0;
      olen_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      word_q  <= word_d;
      olen_q  <= olen_d;
      to_q    <= to_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_dict_start = (state_q == START);
  assign o_dict_word  = buf_q;
  assign o_word_valid = (state_q == DONE);
  assign o_word       = word_q;
  assign o_len        = olen_q;
  assign o_overflow   = ovf_q;
  assign o_timeout    = to_q;

endmodule

// File: tb/tb_word_assembler.sv
module tb_word_assembler;

  logic         clk = 1'b0;
  logic         rst;
  logic         letter_valid;
  logic [4:0]   letter;
  logic         backspace;
  logic         wend;
  logic         ready;
  logic         dict_start;
  logic [119:0] dict_word_o;
  logic         dict_finish;
  logic [119:0] dict_word_i;
  logic         word_valid;
  logic [119:0] word;
  logic [4:0]   len;
  logic         overflow;
  logic         timeout;

  always #5 clk = ~clk;

  word_assembler #(.MAX_LEN(24), .TIMEOUT_CYC(100)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst),
    .i_letter_valid (letter_valid),
    .i_letter       (letter),
    .i_backspace    (backspace),
    .i_end          (wend),
    .o_ready        (ready),
    .o_dict_start   (dict_start),
    .o_dict_word    (dict_word_o),
    .i_dict_finish  (dict_finish),
    .i_dict_word    (dict_word_i),
    .o_word_valid   (word_valid),
    .o_word         (word),
    .o_len          (len),
    .o_overflow     (overflow),
    .o_timeout      (timeout)
  );

  typedef struct packed {
    logic [119:0] w;
    logic [4:0]   len;
    logic         to;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // reference model of the collect buffer
  logic [119:0] m_word;
  int           m_len;

  task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [119:0] rnd_word();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[119:0];
  endfunction

  // Drive one cycle of strobes; when model_on, the model applies the same edit.
  task automatic drive(input bit lv, input logic [4:0] code, input bit bs,
                       input bit en, input bit model_on);
    bit exp_start;
    exp_start = 1'b0;
    if (model_on) begin
      if (bs) begin
        if (m_len > 0) begin
          m_len--;
          m_word[5*m_len +: 5] = 5'd0;
        end
      end else if (lv && code != 5'd0 && m_len < 24) begin
        m_word[5*m_len +: 5] = code;
        m_len++;
      end
      exp_start = en && (m_len > 0);
    end
    letter_valid = lv;
    letter       = code;
    backspace    = bs;
    wend         = en;
    step();
    letter_valid = 1'b0;
    letter       = 5'd0;
    backspace    = 1'b0;
    wend         = 1'b0;
    if (en) begin
      chk("dict_start", dict_start, exp_start);
      if (exp_start) chk("dict_word", dict_word_o, m_word);
    end
  endtask

  task automatic finish_with(input logic [119:0] w);
    sb.push_back('{w: w, len: 5'(m_len), to: 1'b0});
    dict_finish = 1'b1;
    dict_word_i = w;
    step();
    dict_finish = 1'b0;
    dict_word_i = '0;
  endtask

  task automatic wait_commit(input int budget, output int n);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    n = 0;
    while (!seen && n <= budget) begin
      if (word_valid === 1'b1) seen = 1'b1;
      else begin
        step();
        n++;
      end
    end
    chk("commit_seen", seen, 1);
    if (seen) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("o_word", word, e.w);
        chk("o_len", len, e.len);
        chk("o_timeout", timeout, e.to);
      end
      chk("ready_in_done", ready, 0);
      m_word = '0;
      m_len  = 0;
      step();
      chk("valid_one_cycle", word_valid, 0);
      chk("ready_after", ready, 1);
      chk("ovf_cleared", overflow, 0);
    end
  endtask

  initial begin
    int n;
    logic [119:0] x;
    logic [119:0] all24;
    logic [119:0] lit;

    rst          = 1'b1;
    letter_valid = 1'b0;
    letter       = 5'd0;
    backspace    = 1'b0;
    wend         = 1'b0;
    dict_finish  = 1'b0;
    dict_word_i  = '0;
    m_word       = '0;
    m_len        = 0;

    repeat (3) step();
    chk("rst_ready", ready, 0);
    chk("rst_start", dict_start, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_word", word, 0);
    chk("rst_dict_word", dict_word_o, 0);
    chk("rst_len", len, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_to", timeout, 0);
    rst = 1'b0;
    chk("ready_before_edge", ready, 0);
    step();
    chk("ready_first_edge", ready, 1);

    // two letters (one out of the a..z range but non-zero), finish after 10 cycles
    drive(1, 5'd16, 0, 0, 1);
    drive(1, 5'd28, 0, 0, 1);
    drive(0, 5'd0, 0, 1, 1);
    lit = 120'h390;
    chk("w1_dict_word_lit", dict_word_o, lit);
    step();
    chk("start_one_cycle", dict_start, 0);
    repeat (9) step();
    chk("dict_word_held", dict_word_o, lit);
    x = rnd_word();
    finish_with(x);
    wait_commit(5, n);
    chk("finish_latency", n, 0);

    // overflow: 25 letters into a 24-slot buffer
    all24 = '0;
    for (int i = 0; i < 24; i++) all24[5*i +: 5] = 5'd1;
    for (int i = 0; i < 25; i++) begin
      drive(1, 5'd1, 0, 0, 1);
      if (i == 23) chk("ovf_at_full", overflow, 0);
    end
    chk("ovf_set", overflow, 1);
    drive(0, 5'd0, 0, 1, 1);
    chk("w2_dict_word_all24", dict_word_o, all24);
    repeat (3) step();
    finish_with(rnd_word());
    wait_commit(5, n);

    // empty end ignored; padding ignored; backspace
    drive(0, 5'd0, 0, 1, 1);
    chk("empty_end_ready", ready, 1);
    drive(1, 5'd3, 0, 0, 1);
    drive(1, 5'd0, 0, 0, 1);
    drive(1, 5'd4, 0, 0, 1);
    drive(0, 5'd0, 1, 0, 1);
    drive(0, 5'd0, 0, 1, 1);
    lit = 120'd3;
    chk("w3_dict_word_lit", dict_word_o, lit);
    step();
    finish_with(rnd_word());
    wait_commit(5, n);

    // backspace beats letter; letter+end same cycle; dictionary timeout
    drive(1, 5'd2, 0, 0, 1);
    drive(1, 5'd6, 0, 0, 1);
    drive(1, 5'd9, 1, 0, 1);
    drive(1, 5'd8, 0, 1, 1);
    lit = 120'h102;
    chk("w4_dict_word_lit", dict_word_o, lit);
    sb.push_back('{w: m_word, len: 5'(m_len), to: 1'b1});
    wait_commit(150, n);
    chk("timeout_latency", n, 101);

    // reset during WAIT aborts; a late finish is ignored
    drive(1, 5'd1, 0, 0, 1);
    drive(1, 5'd2, 0, 0, 1);
    drive(0, 5'd0, 0, 1, 1);
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("midrst_ready", ready, 0);
    chk("midrst_start", dict_start, 0);
    rst = 1'b0;
    m_word = '0;
    m_len  = 0;
    step();
    chk("postrst_ready", ready, 1);
    chk("postrst_buf", dict_word_o, 0);
    dict_finish = 1'b1;
    dict_word_i = rnd_word();
    step();
    dict_finish = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("no_valid_after_abort", word_valid, 0);
      step();
    end
    drive(0, 5'd0, 0, 1, 1);

    // strobes during WAIT are discarded
    drive(1, 5'd5, 0, 0, 1);
    drive(0, 5'd0, 0, 1, 1);
    step();
    drive(1, 5'd7, 0, 0, 0);
    drive(1, 5'd9, 0, 0, 0);
    drive(0, 5'd0, 1, 0, 0);
    drive(0, 5'd0, 0, 1, 0);
    chk("wait_buf_unchanged", dict_word_o, m_word);
    finish_with(rnd_word());
    wait_commit(5, n);
    drive(1, 5'd11, 0, 0, 1);
    drive(0, 5'd0, 0, 1, 1);
    lit = 120'd11;
    chk("w6_only_new_letter", dict_word_o, lit);
    step();
    finish_with(rnd_word());
    wait_commit(5, n);

    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
